// File: rtl/param_alu.sv
// param_alu: small multi-cycle ALU.
//   add, and and xor complete in one clock. A multiply captures its operands on the start edge
//   and completes MUL_CYCLES clocks later. Illegal opcodes complete at once with err set.
// Ports:
//   clk      - clock; all state changes on its rising edge
//   reset_n  - asynchronous active-low reset
//   A, B     - WIDTH-bit operands, sampled on the start edge
//   op       - 000 nop, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal
//   start    - request strobe; ignored while a multiply is in flight
//   busy     - high while a multiply is in progress
//   done     - one-cycle completion pulse
//   err      - one-cycle pulse together with done for an illegal opcode
//   result   - 2*WIDTH-bit zero-extended result; holds between completions
module param_alu #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned      CntW    = $clog2(MUL_CYCLES + 1);
  // Edge 0 loads MUL_CYCLES-1; the multiply completes on the edge where the counter reads zero,
  // which is edge MUL_CYCLES after the start edge.
  localparam logic [CntW-1:0]  CntLoad = CntW'(MUL_CYCLES - 1);

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;

  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  add_res;
  logic [2*WIDTH-1:0]  and_res;
  logic [2*WIDTH-1:0]  xor_res;
  logic [2*WIDTH-1:0]  mul_res;

  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    add_res = {{(WIDTH - 1){1'b0}}, sum};
    and_res = {{WIDTH{1'b0}}, A & B};
    xor_res = {{WIDTH{1'b0}}, A ^ B};
    mul_res = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              OpNop: ;
              OpAdd: begin
                result <= add_res;
                done   <= 1'b1;
              end
              OpAnd: begin
                result <= and_res;
                done   <= 1'b1;
              end
              OpXor: begin
                result <= xor_res;
                done   <= 1'b1;
              end
              OpMul: begin
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= CntLoad;
                busy    <= 1'b1;
                state_q <= StMul;
              end
              default: begin
                result <= '0;
                done   <= 1'b1;
                err    <= 1'b1;
              end
            endcase
          end
        end
        StMul: begin
          // start is deliberately not looked at here, including on the completing edge.
          if (cnt_q == '0) begin
            result  <= mul_res;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu.sv
module tb_param_alu;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  param_alu #(
    .WIDTH      (8),
    .MUL_CYCLES (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; the DUT samples it on the next rising edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic s);
    @(negedge clk);
    op    = o;
    A     = a;
    B     = b;
    start = s;
  endtask

  task automatic push(input logic [15:0] r, input logic e);
    exp_t x;
    x.res = r;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(result), 32'hDEAD_BEEF);
        end else begin
          x = exp_q.pop_front();
          chk("sb_result", 32'(result), 32'(x.res));
          chk("sb_err", 32'(err), 32'(x.err));
        end
      end else if (err) begin
        chk("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    A       = '0;
    B       = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset_n = 1'b1;

    // Add with carry out.
    issue(3'b001, 8'hFF, 8'h01, 1'b1);
    push(16'h0100, 1'b0);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("add_done", 32'(done), 32'd1);
    chk("add_busy", 32'(busy), 32'd0);

    // Multiply; operands change after the start edge.
    issue(3'b100, 8'hFF, 8'hFF, 1'b1);
    push(16'hFE01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      issue(3'b000, 8'h00, 8'h00, 1'b0);
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_no_early_done", 32'(done), 32'd0);
    end
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("mul_busy_clr", 32'(busy), 32'd0);
    chk("mul_done", 32'(done), 32'd1);

    // Start during busy is ignored.
    issue(3'b100, 8'h12, 8'h34, 1'b1);
    push(16'h03A8, 1'b0);
    issue(3'b001, 8'h01, 8'h01, 1'b1);
    repeat (3) issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("busy_start_done", 32'(done), 32'd1);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("busy_start_single", 32'(done), 32'd0);

    // Start on the completion edge is ignored; next edge accepts.
    issue(3'b100, 8'h03, 8'h05, 1'b1);
    push(16'h000F, 1'b0);
    repeat (2) issue(3'b000, 8'h00, 8'h00, 1'b0);
    issue(3'b001, 8'h01, 8'h01, 1'b1);
    issue(3'b001, 8'h02, 8'h03, 1'b1);
    push(16'h0005, 1'b0);
    chk("cmpl_edge_busy", 32'(busy), 32'd0);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("cmpl_next_result", 32'(result), 32'h0005);
    issue(3'b000, 8'h00, 8'h00, 1'b0);

    // Illegal opcode, then nop.
    issue(3'b110, 8'h12, 8'h34, 1'b1);
    push(16'h0000, 1'b1);
    issue(3'b000, 8'h55, 8'h66, 1'b1);
    chk("illegal_err", 32'(err), 32'd1);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("nop_no_done", 32'(done), 32'd0);
    chk("nop_result_held", 32'(result), 32'd0);

    // Back-to-back xor then and.
    issue(3'b011, 8'hAA, 8'h0F, 1'b1);
    push(16'h00A5, 1'b0);
    issue(3'b010, 8'hAA, 8'h0F, 1'b1);
    push(16'h000A, 1'b0);
    chk("b2b_done1", 32'(done), 32'd1);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("b2b_done2", 32'(done), 32'd1);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("b2b_done_end", 32'(done), 32'd0);

    // Asynchronous reset between edges 1 and 2 of a multiply.
    issue(3'b100, 8'hFF, 8'hFF, 1'b1);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    // First start after release is accepted on the first rising edge.
    @(negedge clk);
    reset_n = 1'b1;
    op      = 3'b001;
    A       = 8'h80;
    B       = 8'h80;
    start   = 1'b1;
    push(16'h0100, 1'b0);
    issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("post_rst_add_done", 32'(done), 32'd1);
    repeat (5) issue(3'b000, 8'h00, 8'h00, 1'b0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 Parameter MUL_CYCLES, default 3, multiply latency in clocks (legal 2..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low; no other clock or reset exists.
REQ-005 A  input  WIDTH  operand A, sampled on the start edge.
REQ-006 B  input  WIDTH  operand B, sampled on the start edge.
REQ-007 op  input  3  opcode: 000 nop, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal.
REQ-008 start  input  1  request strobe, sampled each rising edge.
REQ-009 busy  output  1  high while a multiply is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.
REQ-012 result  output  2*WIDTH  operation result, zero-extended; holds between completions.

Function
REQ-013 FSM states: IDLE and MUL; reset state IDLE.
REQ-014 IDLE, start=1, op in {001,010,011}: result updated and done=1 on the same edge; state stays IDLE.
REQ-015 Add result = A+B as WIDTH+1 bits (carry kept), zero-extended to 2*WIDTH.
REQ-016 And/xor results are WIDTH bits, zero-extended to 2*WIDTH.
REQ-017 IDLE, start=1, op=100: A and B captured into internal registers; busy=1 from this edge; state moves to MUL; cycle counter loaded.
REQ-018 Multiply result = full 2*WIDTH-bit unsigned product of the captured operands; A/B changes after the start edge have no effect.
REQ-019 Multiply completion: done=1 and result updated on the MUL_CYCLES-th rising edge after the start edge (start edge = edge 0); busy=0 and state=IDLE on that same edge.
REQ-020 In MUL, start is ignored: no capture, no extra done, and no queuing.
REQ-021 IDLE, start=1, op=000: no done, no err, result unchanged.
REQ-022 IDLE, start=1, op in 101..111: done=1, err=1, result=0, single cycle.
REQ-023 start=0 in IDLE: outputs done=0, err=0; result holds.
REQ-024 Back-to-back single-cycle ops on consecutive edges each produce their own done pulse; done may remain high across consecutive cycles.
REQ-025 start asserted on the edge where a multiply completes (state still MUL at that edge): ignored; start is accepted again from the next edge.
REQ-026 done and err are never high in the same cycle as busy being set for a new multiply.
REQ-027 Arithmetic is unsigned; no overflow indication beyond the add carry bit.

Reset
REQ-028 reset_n=0 forces immediately, without waiting for clk: state=IDLE, busy=0, done=0, err=0, result=0, counter=0, captured operands=0.
REQ-029 Reset during MUL aborts the multiply; no done is produced after reset_n releases.
REQ-030 First start after reset release is accepted on the first rising edge where reset_n=1.

Verification (WIDTH=8, MUL_CYCLES=3)
REQ-031 Add: A=0xFF, B=0x01, op=001, start 1 cycle -> next edge done=1, result=0x0100, err=0.
REQ-032 Mul: A=0xFF, B=0xFF, op=100; A/B changed to 0 on edge 1 -> busy=1 on edges 0..2, done=1 and result=0xFE01 on edge 3 only.
REQ-033 Start during busy: second start (op=001) on edge 1 of a multiply -> exactly one done (at edge 3), result is the product.
REQ-034 Illegal/nop: op=110 -> done=1, err=1, result=0; then op=000 -> no done, result stays 0.
REQ-035 Async reset mid-multiply: reset_n low between edges 1 and 2 -> busy, done, result go to 0 before the next edge; no done afterwards.
REQ-036 Back-to-back: xor 0xAA^0x0F then and 0xAA&0x0F on consecutive edges -> done high two cycles, results 0x00A5 then 0x000A.
